// File: rtl/ar_arb_pkg.sv
// Shared types and helpers for the AR arbiter: burst encodings, the AR
// payload record and the QoS / round-robin winner selection.
package ar_arb_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Payload field widths; the arbiter's ID/ADDR/LEN parameters must match.
  localparam int AR_ID_W   = 4;
  localparam int AR_ADDR_W = 32;
  localparam int AR_LEN_W  = 8;

  // Upper bound on requesters handled by the winner function.
  localparam int AR_MAX_MASTERS = 16;

  typedef struct packed {
    logic [AR_ID_W-1:0]   id;
    logic [AR_ADDR_W-1:0] addr;
    logic [AR_LEN_W-1:0]  len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic [3:0]           qos;
  } ar_payload_t;

  // Highest QoS wins; among equal QoS the first valid index met when
  // scanning rr_ptr, rr_ptr+1, ... (mod n) wins. Returns 0 if none valid.
  function automatic logic [3:0] ar_pick_winner(
    input logic [AR_MAX_MASTERS-1:0]   valid,
    input logic [AR_MAX_MASTERS*4-1:0] qos,
    input logic [3:0]                  rr_ptr,
    input logic [4:0]                  n
  );
    logic [3:0] win;
    logic [3:0] best;
    logic       found;
    logic [4:0] sum;
    logic [3:0] idx;
    win   = '0;
    best  = '0;
    found = 1'b0;
    for (int k = 0; k < AR_MAX_MASTERS; k++) begin
      if (5'(k) < n) begin
        sum = {1'b0, rr_ptr} + 5'(k);
        if (sum >= n) sum = sum - n;
        idx = sum[3:0];
        if (valid[idx] && (!found || (qos[{idx, 2'b00} +: 4] > best))) begin
          found = 1'b1;
          best  = qos[{idx, 2'b00} +: 4];
          win   = idx;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/ar_arbiter_tag_pool.sv
// Tag pool: free bitmap, lowest-free-tag encoder, tag -> source master
// table, exhaustion flag and double-free error pulse.
module ar_arbiter_tag_pool
  import ar_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int TAG_WIDTH   = 4,
  parameter int SRC_W       = $clog2(NUM_MASTERS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_i,
  input  logic [SRC_W-1:0]     alloc_src_i,
  input  logic                 free_valid_i,
  input  logic [TAG_WIDTH-1:0] free_tag_i,
  input  logic [TAG_WIDTH-1:0] lookup_tag_i,
  output logic [TAG_WIDTH-1:0] alloc_tag_o,
  output logic                 tags_empty_o,
  output logic [SRC_W-1:0]     lookup_src_o,
  output logic                 free_err_o
);

  localparam int NTAGS = 2 ** TAG_WIDTH;

  logic [NTAGS-1:0] free_q, free_d;
  logic [SRC_W-1:0] src_q [NTAGS];
  logic             free_err_q, free_err_d;

  // Lowest-numbered free tag from the start-of-cycle bitmap.
  always_comb begin
    alloc_tag_o = '0;
    for (int t = NTAGS - 1; t >= 0; t--) begin
      if (free_q[t]) alloc_tag_o = TAG_WIDTH'(t);
    end
  end

  // Next bitmap: clear the allocated tag, set a legitimately freed tag.
  // A freed tag is never the allocated one (that one was already free).
  always_comb begin
    free_d     = free_q;
    free_err_d = free_valid_i && free_q[free_tag_i];
    if (alloc_i) free_d[alloc_tag_o] = 1'b0;
    if (free_valid_i && !free_q[free_tag_i]) free_d[free_tag_i] = 1'b1;
  end

  // Bitmap and error pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      free_q     <= '1;
      free_err_q <= 1'b0;
    end else begin
      free_q     <= free_d;
      free_err_q <= free_err_d;
    end
  end

  // Source table: record the owning master of each newly allocated tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NTAGS; t++) src_q[t] <= '0;
    end else if (alloc_i) begin
      src_q[alloc_tag_o] <= alloc_src_i;
    end
  end

  assign tags_empty_o = ~|free_q;
  assign lookup_src_o = src_q[lookup_tag_i];
  assign free_err_o   = free_err_q;

endmodule

// File: rtl/ar_arbiter.sv
// AR channel arbiter: QoS-first, round-robin tie-break, one accept per
// cycle into a single registered output slot, with tag allocation.
//
// Handshake: an upstream request transfers when s_valid[i] & s_ready[i] at
// a clk edge (s_ready may depend on s_valid; s_valid may drop at any time
// before transfer). Downstream transfers when m_valid & m_ready at a clk
// edge; while m_valid & !m_ready the m_* outputs hold stable.
module ar_arbiter
  import ar_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ID_WIDTH    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH   = 8,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_MASTERS-1:0]          s_valid,
  input  logic [NUM_MASTERS*ID_WIDTH-1:0] s_id,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_addr,
  input  logic [NUM_MASTERS*LEN_WIDTH-1:0] s_len,
  input  logic [NUM_MASTERS*3-1:0]        s_size,
  input  logic [NUM_MASTERS*2-1:0]        s_burst,
  input  logic [NUM_MASTERS*4-1:0]        s_qos,
  output logic [NUM_MASTERS-1:0]          s_ready,
  output logic                            m_valid,
  output logic [ID_WIDTH-1:0]             m_id,
  output logic [ADDR_WIDTH-1:0]           m_addr,
  output logic [LEN_WIDTH-1:0]            m_len,
  output logic [2:0]                      m_size,
  output logic [1:0]                      m_burst,
  output logic [3:0]                      m_qos,
  output logic [TAG_WIDTH-1:0]            m_tagid,
  input  logic                            m_ready,
  input  logic                            free_valid,
  input  logic [TAG_WIDTH-1:0]            free_tag,
  input  logic [TAG_WIDTH-1:0]            lookup_tag,
  output logic [$clog2(NUM_MASTERS)-1:0]  lookup_src,
  output logic                            tags_empty,
  output logic                            free_err
);

  localparam int SRC_W = $clog2(NUM_MASTERS);

  logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 m_valid_q;
  ar_payload_t          pay_q, pay_sel;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [TAG_WIDTH-1:0] alloc_tag;
  logic [SRC_W-1:0]     winner;
  logic                 can_load;
  logic                 accept;

  assign can_load = !m_valid_q || m_ready;
  assign winner   = SRC_W'(ar_pick_winner(16'(s_valid), 64'(s_qos),
                                          4'(rr_ptr_q), 5'(NUM_MASTERS)));
  assign accept   = !rst && can_load && !tags_empty && (|s_valid);

  // One-hot ready to the winner only when a grant is possible.
  always_comb begin
    s_ready = '0;
    if (accept) s_ready[winner] = 1'b1;
  end

  // Gather the winning master's AR fields.
  always_comb begin
    pay_sel = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (winner == SRC_W'(i)) begin
        pay_sel.id    = s_id[i*ID_WIDTH +: ID_WIDTH];
        pay_sel.addr  = s_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        pay_sel.len   = s_len[i*LEN_WIDTH +: LEN_WIDTH];
        pay_sel.size  = s_size[i*3 +: 3];
        pay_sel.burst = s_burst[i*2 +: 2];
        pay_sel.qos   = s_qos[i*4 +: 4];
      end
    end
  end

  // Round-robin pointer moves just past the accepted master.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (winner == SRC_W'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;
    end
  end

  // Output slot: load on accept, empty on drain, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      pay_q     <= '0;
      tag_q     <= '0;
      rr_ptr_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (can_load) begin
        m_valid_q <= accept;
        if (accept) begin
          pay_q <= pay_sel;
          tag_q <= alloc_tag;
        end
      end
    end
  end

  ar_arbiter_tag_pool #(
    .NUM_MASTERS (NUM_MASTERS),
    .TAG_WIDTH   (TAG_WIDTH),
    .SRC_W       (SRC_W)
  ) u_tag_pool (
    .clk          (clk),
    .rst          (rst),
    .alloc_i      (accept),
    .alloc_src_i  (winner),
    .free_valid_i (free_valid),
    .free_tag_i   (free_tag),
    .lookup_tag_i (lookup_tag),
    .alloc_tag_o  (alloc_tag),
    .tags_empty_o (tags_empty),
    .lookup_src_o (lookup_src),
    .free_err_o   (free_err)
  );

  assign m_valid = m_valid_q;
  assign m_id    = pay_q.id;
  assign m_addr  = pay_q.addr;
  assign m_len   = pay_q.len;
  assign m_size  = pay_q.size;
  assign m_burst = pay_q.burst;
  assign m_qos   = pay_q.qos;
  assign m_tagid = tag_q;

endmodule

// File: tb/tb_ar_arbiter.sv
// Directed bench for ar_arbiter with hand-computed expectations.
module tb_ar_arbiter;
  import ar_arb_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  s_valid;
  logic [15:0] s_id;
  logic [127:0] s_addr;
  logic [31:0] s_len;
  logic [11:0] s_size;
  logic [7:0]  s_burst;
  logic [15:0] s_qos;
  logic [3:0]  s_ready;
  logic        m_valid;
  logic [3:0]  m_id;
  logic [31:0] m_addr;
  logic [7:0]  m_len;
  logic [2:0]  m_size;
  logic [1:0]  m_burst;
  logic [3:0]  m_qos;
  logic [3:0]  m_tagid;
  logic        m_ready;
  logic        free_valid;
  logic [3:0]  free_tag;
  logic [3:0]  lookup_tag;
  logic [1:0]  lookup_src;
  logic        tags_empty;
  logic        free_err;

  int n_checks = 0;
  int n_errors = 0;

  ar_arbiter dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_id(s_id), .s_addr(s_addr), .s_len(s_len),
    .s_size(s_size), .s_burst(s_burst), .s_qos(s_qos), .s_ready(s_ready),
    .m_valid(m_valid), .m_id(m_id), .m_addr(m_addr), .m_len(m_len),
    .m_size(m_size), .m_burst(m_burst), .m_qos(m_qos), .m_tagid(m_tagid),
    .m_ready(m_ready), .free_valid(free_valid), .free_tag(free_tag),
    .lookup_tag(lookup_tag), .lookup_src(lookup_src),
    .tags_empty(tags_empty), .free_err(free_err)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    s_valid = '0; s_id = '0; s_addr = '0; s_len = '0; s_size = '0;
    s_burst = '0; s_qos = '0; m_ready = 1'b1; free_valid = 1'b0;
    free_tag = '0; lookup_tag = '0;
  endtask

  task automatic set_req(input int m, input logic [31:0] addr, input logic [3:0] qos);
    s_valid[m]          = 1'b1;
    s_id[m*4 +: 4]      = 4'(m);
    s_addr[m*32 +: 32]  = addr;
    s_len[m*8 +: 8]     = 8'(m + 1);
    s_size[m*3 +: 3]    = 3'd2;
    s_burst[m*2 +: 2]   = BURST_INCR;
    s_qos[m*4 +: 4]     = qos;
  endtask

  // Advance to just after the next active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    s_valid = 4'hF;
    step();
    step();
    // Reset state, with requests present to show s_ready is gated.
    @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_tags_empty", 32'(tags_empty), 32'd0);
    chk("rst_free_err", 32'(free_err), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_tagid", 32'(m_tagid), 32'd0);
    step();
    rst = 1'b0;
    clear_inputs();

    // Single requester, master 2.
    set_req(2, 32'h1000, 4'd0);
    @(negedge clk);
    chk("single_s_ready", 32'(s_ready), 32'b0100);
    step();
    s_valid = '0;
    lookup_tag = 4'd0;
    chk("single_m_valid", 32'(m_valid), 32'd1);
    chk("single_m_addr", m_addr, 32'h1000);
    chk("single_m_tagid", 32'(m_tagid), 32'd0);
    chk("single_m_len", 32'(m_len), 32'd3);
    chk("single_lookup", 32'(lookup_src), 32'd2);

    // Round robin over four equal-QoS masters.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 32'h2000 + 32'(i * 16), 4'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_s_ready", 32'(s_ready), 32'(1 << (k % 4)));
      step();
      chk("rr_m_id", 32'(m_id), 32'(k % 4));
      chk("rr_m_tagid", 32'(m_tagid), 32'(k));
    end
    s_valid = '0;
    lookup_tag = 4'd3;
    #1 chk("rr_lookup3", 32'(lookup_src), 32'd3);
    lookup_tag = 4'd4;
    #1 chk("rr_lookup4", 32'(lookup_src), 32'd0);

    // QoS beats round robin (rr_ptr now 1).
    set_req(0, 32'h3000, 4'd1);
    set_req(3, 32'h3300, 4'd7);
    @(negedge clk);
    chk("qos_s_ready0", 32'(s_ready), 32'b1000);
    step();
    s_valid[3] = 1'b0;
    chk("qos_m_id0", 32'(m_id), 32'd3);
    chk("qos_m_qos0", 32'(m_qos), 32'd7);
    chk("qos_m_tag0", 32'(m_tagid), 32'd5);
    @(negedge clk);
    chk("qos_s_ready1", 32'(s_ready), 32'b0001);
    step();
    chk("qos_m_id1", 32'(m_id), 32'd0);
    chk("qos_m_tag1", 32'(m_tagid), 32'd6);

    // Backpressure: hold slot for 5 cycles, then release (rr_ptr = 1).
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 32'h4000 + 32'(i * 16), 4'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_s_ready", 32'(s_ready), 32'd0);
      chk("hold_m_valid", 32'(m_valid), 32'd1);
      chk("hold_m_addr", m_addr, 32'h3000);
      chk("hold_m_tagid", 32'(m_tagid), 32'd6);
      step();
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk("release_s_ready", 32'(s_ready), 32'b0010);
    step();
    chk("release_m_id", 32'(m_id), 32'd1);
    chk("release_m_tagid", 32'(m_tagid), 32'd7);

    // Exhaustion of all 16 tags.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 32'h5000 + 32'(i * 16), 4'd0);
    for (int k = 0; k < 16; k++) step();
    chk("exh_last_tag", 32'(m_tagid), 32'd15);
    @(negedge clk);
    chk("exh_tags_empty", 32'(tags_empty), 32'd1);
    chk("exh_s_ready", 32'(s_ready), 32'd0);
    step();
    free_valid = 1'b1;
    free_tag   = 4'd5;
    @(negedge clk);
    chk("exh_free_same_cycle", 32'(s_ready), 32'd0);
    step();
    free_valid = 1'b0;
    @(negedge clk);
    chk("exh_not_empty", 32'(tags_empty), 32'd0);
    chk("exh_regrant", 32'(s_ready), 32'b0001);
    step();
    s_valid = '0;
    chk("exh_m_tagid", 32'(m_tagid), 32'd5);
    chk("exh_m_id", 32'(m_id), 32'd0);
    // Legit free of tag 5, then a double free.
    free_valid = 1'b1;
    free_tag   = 4'd5;
    step();
    chk("free_ok_err", 32'(free_err), 32'd0);
    step();
    free_valid = 1'b0;
    chk("double_free_err", 32'(free_err), 32'd1);
    step();
    chk("double_free_pulse", 32'(free_err), 32'd0);
    chk("double_free_empty", 32'(tags_empty), 32'd0);

    // Free tag 2 while tag 3 is being allocated.
    do_reset();
    set_req(1, 32'h6000, 4'd2);
    step(); step(); step();
    chk("sim_pre_tag", 32'(m_tagid), 32'd2);
    free_valid = 1'b1;
    free_tag   = 4'd2;
    @(negedge clk);
    chk("sim_s_ready", 32'(s_ready), 32'b0010);
    step();
    free_valid = 1'b0;
    chk("sim_tag3", 32'(m_tagid), 32'd3);
    chk("sim_free_err", 32'(free_err), 32'd0);
    step();
    s_valid = '0;
    chk("sim_tag2", 32'(m_tagid), 32'd2);
    lookup_tag = 4'd3;
    #1 chk("sim_lookup3", 32'(lookup_src), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ar_arbiter.md
Name: ar_arbiter

Overview:
- Shares one downstream AR channel between NUM_MASTERS upstream read-address requesters.
- Arbitrates by QoS, with round-robin tie-break.
- Allocates an internal tag from a pool for each accepted request and records which master owns that tag.
- Sits in front of the reorder buffer; the response path frees tags and looks up the source master.

Parameters:
- NUM_MASTERS, 4, number of upstream AR requesters (≥2).
- ID_WIDTH, 4, AXI transaction ID width.
- ADDR_WIDTH, 32, address width.
- LEN_WIDTH, 8, burst length width.
- TAG_WIDTH, 4, internal tag width; pool holds 2**TAG_WIDTH tags.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  NUM_MASTERS  per-master request valid.
- s_id  in  NUM_MASTERS*ID_WIDTH  per-master ID; master i at slice [i*ID_WIDTH +: ID_WIDTH]. Same slicing for all s_* buses.
- s_addr  in  NUM_MASTERS*ADDR_WIDTH  per-master address.
- s_len  in  NUM_MASTERS*LEN_WIDTH  per-master burst length.
- s_size  in  NUM_MASTERS*3  per-master beat size.
- s_burst  in  NUM_MASTERS*2  per-master burst type.
- s_qos  in  NUM_MASTERS*4  per-master QoS.
- s_ready  out  NUM_MASTERS  per-master accept (combinational).
- m_valid, m_id, m_addr, m_len, m_size, m_burst, m_qos, m_tagid  out  1/ID/ADDR/LEN/3/2/4/TAG  registered downstream AR channel.
- m_ready  in  1  downstream accept.
- free_valid  in  1  response path returns a tag.
- free_tag  in  TAG_WIDTH  tag being returned.
- lookup_tag  in  TAG_WIDTH  tag to query.
- lookup_src  out  $clog2(NUM_MASTERS)  master that owns lookup_tag (combinational).
- tags_empty  out  1  no free tag remains (registered-state derived).
- free_err  out  1  one-cycle pulse: freed tag was not allocated.

Behaviour:
- Reset (rst=1 at clk edge):
  - m_valid=0 and all m_* data=0.
  - All tags free; tags_empty=0; free_err=0.
  - rr_ptr=0; src table cleared to 0.
  - s_ready is forced to 0 while rst=1.
- Output stage is one register slot. can_load = !m_valid | m_ready.
- Grant (combinational):
  - Requires can_load, at least one tag free, and at least one s_valid.
  - Winner = requester with highest s_qos.
  - QoS ties go to the first valid index scanning rr_ptr, rr_ptr+1, … modulo NUM_MASTERS.
  - s_ready[winner]=1; all other s_ready=0. Only one accept per cycle.
- Accept (s_valid[w] & s_ready[w]) at clk edge:
  - Output register loads master w's fields; m_valid=1.
  - m_tagid = lowest-numbered free tag; that tag is marked allocated.
  - src[tag] = w.
  - rr_ptr = (w+1) mod NUM_MASTERS.
- Latency: request accepted in cycle N appears on m_* in cycle N+1.
- Full throughput is one request per cycle while m_ready=1 and tags are available.
- Hold: if m_valid & !m_ready, all m_* are held stable and no grant occurs.
- Free:
  - free_valid with an allocated free_tag marks it free at the clk edge.
  - The tag is allocatable from the next cycle.
  - Free of an already-free tag: no state change; free_err=1 for one cycle.
- Simultaneous free and accept: allocation uses the free vector from the start of the cycle. A tag freed this cycle is not reused this cycle. Both updates apply.
- Exhaustion: when all tags are allocated, tags_empty=1 and s_ready=0. The pending m_* may still drain.
- s_valid is not required to stay stable. The arbiter never relies on s_valid persistence, and an unaccepted request may be withdrawn.
- lookup_src = src[lookup_tag], combinational; undefined for unallocated tags (returns stale value).
- Reset mid-operation: in-flight m_valid is dropped and all tags are reclaimed. No error is raised.

Decomposition:
- Package ar_arb_pkg holds:
  - Burst encodings FIXED=2'b00, INCR=2'b01, WRAP=2'b10.
  - A struct for AR payload (id, addr, len, size, burst, qos).
  - A function computing the round-robin/QoS winner.
- One natural sub-module: tag_pool. It owns the free bitmap, lowest-free priority encoder, src table, tags_empty and free_err.

Test Plan:
- Reset, then master 2 requests alone with addr 0x1000, qos 0 -> s_ready[2]=1 same cycle; next cycle m_valid=1, m_addr=0x1000, m_tagid=0, lookup_src(0)=2.
- All 4 masters valid with qos 0 and m_ready=1 held -> grants in order 0,1,2,3,0; tags 0,1,2,3,4.
- Masters 0 and 3 valid with qos 1 and 7 -> master 3 wins regardless of rr_ptr; then master 0.
- m_ready=0 for 5 cycles with m_valid=1 -> m_* stable, all s_ready=0; release -> next grant same cycle m_ready rises.
- Allocate all 16 tags -> tags_empty=1, s_ready=0. free tag 5 -> next cycle a grant is issued with m_tagid=5. Free tag 5 again -> free_err pulse.
- free tag 2 in the same cycle tag 3 is allocated -> tag 3 issued; tag 2 is issued on the following grant.
